// File: rtl/ins_mem_param.sv
// Parametrised instruction memory: clocked fetch port, runtime loader,
// and a self-sequenced boot that clears the array and installs a default program.
module ins_mem_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  output logic              ld_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    READY = 2'd1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              err_q;

  logic              we;
  logic              fetch;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] boot_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = READY;
      end
      READY: ;
      default: begin
        state_d = BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    boot_word = '0;
    case (cnt_q)
      'd0: boot_word = DATA_W'(12'h200);
      'd1: boot_word = DATA_W'(12'h201);
      'd2: boot_word = DATA_W'(12'h204);
      'd3: boot_word = DATA_W'(12'h108);
      default: boot_word = '0;
    endcase
  end

  // Array writes are gated by reset so a held reset never disturbs contents.
  always_comb begin
    busy  = (state_q != READY) | ld_en;
    fetch = (state_q == READY) & req & ~ld_en;
    we    = 1'b0;
    waddr = cnt_q[ADDR_W-1:0];
    wdata = boot_word;
    if (state_q == BOOT) begin
      we = ~reset;
    end else if (state_q == READY) begin
      we    = ld_en;
      waddr = ld_addr;
      wdata = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= fetch;
      err_q   <= (state_q != READY) & ld_en;
      if (fetch) instr_q <= mem_q[pc];
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign ld_err      = err_q;

endmodule

// File: tb/tb_ins_mem_param.sv
// Directed bench for ins_mem_param: default 32x32 instance and a 16x8 instance.
module tb_ins_mem_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  logic        a_rst, a_req, a_ld_en;
  logic [4:0]  a_pc, a_ld_addr;
  logic [31:0] a_ld_data, a_instr;
  logic        a_valid, a_busy, a_err;

  ins_mem_param #(.DATA_W(32), .ADDR_W(5)) u_a (
    .clk(clk), .reset(a_rst), .req(a_req), .pc(a_pc),
    .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
    .instr(a_instr), .instr_valid(a_valid), .busy(a_busy),
    .ld_err(a_err)
  );

  logic        b_rst, b_req, b_ld_en;
  logic [2:0]  b_pc, b_ld_addr;
  logic [15:0] b_ld_data, b_instr;
  logic        b_valid, b_busy, b_err;

  ins_mem_param #(.DATA_W(16), .ADDR_W(3)) u_b (
    .clk(clk), .reset(b_rst), .req(b_req), .pc(b_pc),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .instr(b_instr), .instr_valid(b_valid), .busy(b_busy),
    .ld_err(b_err)
  );

  logic [31:0] boot_exp [5];

  initial begin
    boot_exp[0] = 32'h200;
    boot_exp[1] = 32'h201;
    boot_exp[2] = 32'h204;
    boot_exp[3] = 32'h108;
    boot_exp[4] = 32'h0;

    a_rst = 1'b1; a_req = 1'b0; a_pc = '0;
    a_ld_en = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    b_rst = 1'b1; b_req = 1'b0; b_pc = '0;
    b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h1);
    chk("rst_err", 32'(a_err), 32'h0);

    // boot with req held; stray load on boot cycle 5
    a_rst = 1'b0; a_req = 1'b1; a_pc = 5'd0;
    for (int k = 0; k < 32; k++) begin
      if (k == 4) begin
        a_ld_en = 1'b1; a_ld_addr = 5'd2; a_ld_data = 32'hFFFF_FFFF;
      end
      #1 chk($sformatf("boot_busy%0d", k), 32'(a_busy), 32'h1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("boot_valid%0d", k), 32'(a_valid), 32'h0);
      if (k == 4) begin
        chk("boot_lderr_pulse", 32'(a_err), 32'h1);
        a_ld_en = 1'b0;
      end
      if (k == 5) chk("boot_lderr_clear", 32'(a_err), 32'h0);
    end
    #1 chk("ready_busy", 32'(a_busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("first_valid", 32'(a_valid), 32'h1);
    chk("first_instr", a_instr, 32'h200);

    // back-to-back fetch of the default program
    a_pc = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_valid%0d", i), 32'(a_valid), 32'h1);
      chk($sformatf("b2b_instr%0d", i), a_instr, boot_exp[i]);
      if (i < 4) a_pc = 5'(i + 1);
    end
    a_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_valid", 32'(a_valid), 32'h0);
    chk("idle_hold", a_instr, 32'h0);

    // load wins over simultaneous fetch
    a_ld_en = 1'b1; a_ld_addr = 5'd7; a_ld_data = 32'hDEAD_BEEF;
    a_req = 1'b1; a_pc = 5'd7;
    #1 chk("ld_busy", 32'(a_busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("ld_drop_valid", 32'(a_valid), 32'h0);
    chk("ld_no_err", 32'(a_err), 32'h0);
    a_ld_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ld_rd_valid", 32'(a_valid), 32'h1);
    chk("ld_rd_instr", a_instr, 32'hDEAD_BEEF);

    a_pc = 5'd2;
    @(posedge clk);
    @(negedge clk);
    chk("boot_ld_ignored", a_instr, 32'h204);

    // write-then-read, then reset during a pending fetch
    a_req = 1'b0;
    a_ld_en = 1'b1; a_ld_addr = 5'd3; a_ld_data = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    a_ld_en = 1'b0; a_req = 1'b1; a_pc = 5'd3;
    @(posedge clk);
    @(negedge clk);
    chk("wtr_valid", 32'(a_valid), 32'h1);
    chk("wtr_instr", a_instr, 32'h1234_5678);
    a_rst = 1'b1;
    #1;
    chk("mid_rst_instr", a_instr, 32'h0);
    chk("mid_rst_valid", 32'(a_valid), 32'h0);
    chk("mid_rst_busy", 32'(a_busy), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_rst_valid", 32'(a_valid), 32'h0);
    a_rst = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    chk("reboot_valid", 32'(a_valid), 32'h0);
    #1 chk("reboot_busy", 32'(a_busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("reboot_valid2", 32'(a_valid), 32'h1);
    chk("reboot_instr", a_instr, 32'h108);
    a_pc = 5'd7;
    @(posedge clk);
    @(negedge clk);
    chk("reboot_clear", a_instr, 32'h0);
    a_req = 1'b0;

    // narrow instance: 8-cycle boot
    @(negedge clk);
    b_rst = 1'b0; b_req = 1'b1; b_pc = 3'd3;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("n_boot_busy%0d", k), 32'(b_busy), 32'h1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("n_boot_valid%0d", k), 32'(b_valid), 32'h0);
    end
    #1 chk("n_ready_busy", 32'(b_busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("n_valid3", 32'(b_valid), 32'h1);
    chk("n_instr3", 32'(b_instr), 32'h0108);
    b_pc = 3'd7;
    @(posedge clk);
    @(negedge clk);
    chk("n_valid7", 32'(b_valid), 32'h1);
    chk("n_instr7", 32'(b_instr), 32'h0000);
    b_pc = 3'd2;
    @(posedge clk);
    @(negedge clk);
    chk("n_instr2", 32'(b_instr), 32'h0204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
